// File: rtl/ika9958_dlclk_sync.sv
// ika9958_dlclk_sync: slave-side DLCLK_n receiver that locks to a 4-tick period and regenerates phiL/phiH enables
module ika9958_dlclk_sync #(
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2
) (
  input  logic       i_phiA,
  input  logic       i_RST,
  input  logic       i_phiA_NCEN,
  input  logic       i_EN,
  input  logic       i_DLCLK_n,
  output logic       o_phiL_PCEN,
  output logic       o_phiL_NCEN,
  output logic       o_phiH_PCEN,
  output logic       o_phiH_NCEN,
  output logic       o_LOCKED,
  output logic       o_HOLD,
  output logic       o_SLIP,
  output logic [1:0] o_PHASE,
  output logic [7:0] o_ERRCNT
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, HOLDOVER} state_t;
  state_t     state;
  logic [2:0] cnt;
  logic [3:0] good;
  logic [1:0] miss;
  logic [1:0] sync;
  logic       hist;
  logic       ev;
  logic       per_ok;
  logic       locked;
  logic       act;
  logic [7:0] err_next;
  assign ev       = ~sync[1] & hist;
  assign per_ok   = cnt == 3'd3;
  assign locked   = state == LOCKED || state == HOLDOVER;
  assign act      = i_phiA_NCEN & locked;
  assign err_next = o_ERRCNT + {7'd0, o_ERRCNT != 8'hff};
  // Phase-derived enables are gated by the tick so nothing fires on stalled cycles
  always_comb begin
    o_phiL_PCEN = act & (cnt[1:0] == 2'd0);
    o_phiL_NCEN = act & (cnt[1:0] == 2'd2);
    o_phiH_PCEN = act & ~cnt[0];
    o_phiH_NCEN = act & cnt[0];
    o_LOCKED    = locked;
    o_HOLD      = state == HOLDOVER;
    o_PHASE     = locked ? cnt[1:0] : 2'd0;
  end
  // Synchronizer, period checker and lock/holdover state machine; the slip pulse self-clears every cycle
  always_ff @(posedge i_phiA) begin
    if (i_RST) begin
      state    <= IDLE;
      cnt      <= 3'd7;
      good     <= 4'd0;
      miss     <= 2'd0;
      sync     <= 2'b11;
      hist     <= 1'b1;
      o_SLIP   <= 1'b0;
      o_ERRCNT <= 8'd0;
    end else begin
      o_SLIP <= 1'b0;
      if (i_phiA_NCEN) begin
        sync <= {sync[0], i_DLCLK_n};
        hist <= sync[1];
        if (!i_EN) begin
          state <= IDLE;
          cnt   <= 3'd7;
          good  <= 4'd0;
          miss  <= 2'd0;
        end else if (state == IDLE) begin
          state <= ACQUIRE;
          cnt   <= 3'd7;
          good  <= 4'd0;
        end else if (state == ACQUIRE) begin
          if (ev) begin
            cnt  <= 3'd0;
            good <= per_ok ? good + 4'd1 : 4'd0;
            if (per_ok && good == 4'(LOCK_CNT - 1)) begin
              state <= LOCKED;
              good  <= 4'd0;
            end
          end else begin
            cnt <= (cnt == 3'd7) ? cnt : cnt + 3'd1;
          end
        end else if (ev && !per_ok) begin
          o_SLIP   <= 1'b1;
          o_ERRCNT <= err_next;
          state    <= ACQUIRE;
          good     <= 4'd0;
          miss     <= 2'd0;
          cnt      <= 3'd0;
        end else if (ev) begin
          state <= LOCKED;
          miss  <= 2'd0;
          cnt   <= 3'd0;
        end else begin
          cnt <= {1'b0, cnt[1:0] + 2'd1};
          if (per_ok && state == LOCKED) begin
            state <= HOLDOVER;
            miss  <= 2'd1;
          end else if (per_ok && ({1'b0, miss} + 3'd1) >= 3'(MISS_MAX)) begin
            o_SLIP   <= 1'b1;
            o_ERRCNT <= err_next;
            state    <= ACQUIRE;
            cnt      <= 3'd7;
            good     <= 4'd0;
            miss     <= 2'd0;
          end else if (per_ok) begin
            miss <= miss + 2'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ika9958_dlclk_sync.sv
// tb_ika9958_dlclk_sync: directed check of lock, slip, holdover, stall, disable and reset behaviour
module tb_ika9958_dlclk_sync;
  logic       clk = 1'b0;
  logic       rst, ncen, en, dl, stall;
  logic       phil_p, phil_n, phih_p, phih_n, locked, hold, slip;
  logic [1:0] phase;
  logic [7:0] errcnt;
  int         n_chk = 0;
  int         n_fail = 0;

  ika9958_dlclk_sync dut (
    .i_phiA(clk), .i_RST(rst), .i_phiA_NCEN(ncen), .i_EN(en), .i_DLCLK_n(dl),
    .o_phiL_PCEN(phil_p), .o_phiL_NCEN(phil_n), .o_phiH_PCEN(phih_p), .o_phiH_NCEN(phih_n),
    .o_LOCKED(locked), .o_HOLD(hold), .o_SLIP(slip), .o_PHASE(phase), .o_ERRCNT(errcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic d);
    if (stall) begin
      ncen = 1'b0;
      @(posedge clk); #1;
      chk("stall_en", {phil_p, phil_n, phih_p, phih_n}, 0);
    end
    ncen = 1'b1;
    dl = d;
    @(posedge clk); #1;
  endtask

  task automatic chk_tick(input logic [1:0] ph, input logic lk, input logic hd);
    chk("phase", phase, lk ? ph : 2'd0);
    chk("locked", locked, lk);
    chk("hold", hold, hd);
    chk("enables", {phil_p, phil_n, phih_p, phih_n},
        lk ? {ph == 2'd0, ph == 2'd2, ~ph[0], ph[0]} : 4'd0);
  endtask

  task automatic period();
    step(0); step(0); step(1); step(1);
  endtask

  task automatic lock_seq();
    repeat (4) period();
    step(0); step(0);
    chk("pre_lock", locked, 0);
    step(1); chk_tick(2'd0, 1, 0);
    step(1); chk_tick(2'd1, 1, 0);
  endtask

  task automatic run_locked(input int n);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        step(k < 2 ? 1'b0 : 1'b1);
        chk_tick(2'(k + 2), 1, 0);
      end
  endtask

  task automatic do_slip(input logic [7:0] exp_err);
    step(0); chk_tick(2'd2, 1, 0);
    step(0); chk_tick(2'd3, 1, 0);
    step(1); chk_tick(2'd0, 1, 0);
    step(0); chk_tick(2'd1, 1, 0);
    step(0); chk_tick(2'd2, 1, 0);
    step(1);
    chk("slip_pulse", {slip, locked}, 2'b10);
    chk("slip_err", errcnt, exp_err);
    step(1);
    chk("slip_clear", slip, 0);
    repeat (3) period();
    chk("relock_early", locked, 0);
    period();
    chk_tick(2'd1, 1, 0);
    chk("relock_err", errcnt, exp_err);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ncen = 1'b1; dl = 1'b1; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {phil_p, phil_n, phih_p, phih_n, locked, hold, slip, phase, errcnt}, 0);
    rst = 1'b0; en = 1'b1;

    lock_seq();
    run_locked(2);
    chk("clean_err", errcnt, 0);

    do_slip(8'd1);

    for (int k = 0; k < 4; k++) begin
      step(1);
      chk_tick(2'(k + 2), 1, k >= 2);
    end
    for (int k = 0; k < 4; k++) begin
      step(k < 2 ? 1'b0 : 1'b1);
      chk_tick(2'(k + 2), 1, k < 2);
    end
    chk("hold_err", errcnt, 1);

    for (int k = 0; k < 4; k++) begin
      step(1);
      chk_tick(2'(k + 2), 1, k >= 2);
    end
    step(1); chk_tick(2'd2, 1, 1);
    step(1); chk_tick(2'd3, 1, 1);
    step(1);
    chk("miss_slip", {slip, locked, hold}, 3'b100);
    chk("miss_err", errcnt, 2);
    step(1);
    chk("miss_clear", slip, 0);
    lock_seq();

    en = 1'b0;
    step(0);
    chk("en_drop", {locked, hold, slip, phase}, 0);
    chk("en_drop_err", errcnt, 2);

    en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(0); step(0); step(1); step(1); step(1);
      chk("wrong_period", {locked, phil_p, phil_n, phih_p, phih_n}, 0);
    end
    chk("wrong_err", errcnt, 2);

    en = 1'b0; step(1);
    en = 1'b1; step(1);
    lock_seq();
    do_slip(8'd3);

    rst = 1'b1; ncen = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid", {phil_p, phil_n, phih_p, phih_n, locked, hold, slip, phase, errcnt}, 0);
    rst = 1'b0;

    stall = 1'b1;
    lock_seq();
    run_locked(2);
    chk("stall_err", errcnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
